sap_datapath: RTL and testbench
===============================

Name: sap_datapath

Overview:
- Datapath and bus responder for the 8-bit SAP-style CPU.
- Consumes the 15-bit control word driven by the control block and executes the register transfers it encodes over a shared 8-bit bus.
- Contains the PC, MAR, MDR, 16x8 RAM, IR, A, B, adder/subtractor, flags and output register.
- Returns the IR opcode to the control block.

Parameters:
- RAM_DEPTH, 16, RAM words; fixed to 16 because addresses are 4 bits.
- DATA_W, 8, bus and register width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ctrl  in  15  control word. Bit meanings:
  - 14 C_P: PC increment.
  - 13 E_P: PC drives the bus.
  - 12 L_P: PC loads from the bus.
  - 11 \L_MA: MAR loads address (active-low).
  - 10 \L_MD: MDR loads data (active-low).
  - 9 \CE: RAM drives the bus (active-low).
  - 8 \L_R: RAM write (active-low).
  - 7 \L_I: IR loads (active-low).
  - 6 \E_I: IR operand drives the bus (active-low).
  - 5 \L_A: A loads (active-low).
  - 4 E_A: A drives the bus.
  - 3 S_U: subtract select.
  - 2 E_U: ALU drives the bus.
  - 1 \L_B: B loads (active-low).
  - 0 \L_O: OUT loads (active-low).
- prog_we  in  1  program-load write strobe.
- prog_addr  in  4  program-load address.
- prog_data  in  8  program-load data.
- opcode  out  4  IR[7:4], to the control block.
- out_value  out  8  output register.
- pc_value  out  4  current PC, for debug.
- bus_value  out  8  current bus value, for debug.
- flag_c  out  1  carry flag.
- flag_z  out  1  zero flag.
- bus_conflict  out  1  sticky multiple-driver error.

Behaviour:
- Reset (rst=1 at a rising edge): PC, MAR, MDR, IR, A, B, OUT, flag_c, flag_z and bus_conflict all clear to 0.
  - RAM contents are preserved.
  - prog_we still writes during reset.
- Bus:
  - The bus is combinational from the current ctrl and register values.
  - Driver priority: E_P > !\CE > !\E_I > E_A > E_U.
  - E_P drives {4'h0,PC}. !\CE drives RAM[MAR]. !\E_I drives {4'h0,IR[3:0]}. E_A drives A. E_U drives the ALU result.
  - No driver enabled: bus = 8'h00.
  - bus_conflict: two or more drivers enabled at a rising edge sets it; it stays set until reset.
- ALU (combinational):
  - S_U=0: sum = A + B.
  - S_U=1: sum = A + ~B + 1.
  - Result is sum[7:0]; carry is sum[8]. For subtract, carry=1 means no borrow.
  - flag_c and flag_z latch carry and (result==0) at a rising edge with E_U=1; otherwise they hold.
- Register loads (rising edge, using the bus value in that cycle):
  - !\L_MA: MAR <= bus[3:0].
  - !\L_MD: MDR <= bus.
  - !\L_I: IR <= bus.
  - !\L_A: A <= bus.
  - !\L_B: B <= bus.
  - !\L_O: OUT <= bus.
- PC:
  - L_P loads PC <= bus[3:0].
  - Otherwise C_P increments PC by 1, wrapping 15 -> 0.
  - L_P with C_P in the same cycle: L_P wins.
- RAM write:
  - !\L_R writes RAM[MAR] <= MDR using the pre-edge MAR and MDR.
  - \L_MD and \L_R together in one cycle write the old MDR. The controller must sequence MDR load one cycle before the write.
- RAM read:
  - Asynchronous: RAM[MAR].
  - A read and a write in the same cycle return the old data.
- Program port:
  - prog_we writes RAM[prog_addr] <= prog_data at the rising edge.
  - If !\L_R targets the same address in the same cycle, prog_we wins.
- Same-cycle source and destination (e.g. E_A with !\L_A): the register reloads its own value, with no change.
- Idle control word 15'b000111111100011: all active-low strobes deasserted and no drivers, so no state changes.
  - The control block drives ctrl=0 while it is in reset, which asserts all active-low strobes. Hold rst high over the same window so nothing changes.
- Latency:
  - Register outputs update one rising edge after the ctrl is presented.
  - opcode is valid the cycle after the IR load.
  - out_value is valid the cycle after the OUT load.

Test Plan:
1. Preload RAM[0]=8'h4E, RAM[14]=8'h07 via the program port, then release rst.
   - Fetch: ctrl E_P,!\L_MA, then !\CE,!\L_I,C_P.
   - Expect opcode=4 and pc_value=1.
   - Execute: !\E_I,!\L_MA, then !\CE,!\L_A. Expect A=8'h07.
2. A=8'h07, B=8'h09.
   - E_U,S_U=0,!\L_O → out_value=8'h10, flag_c=0, flag_z=0.
   - S_U=1 → out_value=8'hFE, flag_c=0.
   - A=B=8'h09 with subtract → result 0, flag_z=1, flag_c=1.
3. A=8'hFF, B=8'h01, add → result 8'h00, flag_c=1, flag_z=1.
4. PC at 15 with C_P → PC=0.
   - L_P with bus {4'h0,4'h5} and C_P in the same cycle → PC=5.
5. STA: MAR=4'hA, then E_A(A=8'h3C),!\L_MD, then !\L_R.
   - !\CE read of RAM[10] returns 8'h3C.
   - Same-cycle !\L_MD with !\L_R writes the previous MDR.
6. E_P and E_A together → bus shows the PC value; bus_conflict=1 and stays 1.
   - rst clears all registers and bus_conflict but leaves RAM intact.
   - Idle ctrl 15'b000111111100011 for 10 cycles → no state change.

Source files
------------

// File: rtl/sap_datapath_if.sv
// Control/program/observation signals between the SAP control block (master)
// and the datapath (slave).
interface sap_datapath_if #(
  parameter int DATA_W = 8
);
  logic [14:0]       ctrl;
  logic              prog_we;
  logic [3:0]        prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] out_value;
  logic [3:0]        pc_value;
  logic [DATA_W-1:0] bus_value;
  logic              flag_c;
  logic              flag_z;
  logic              bus_conflict;

  modport master (
    output ctrl, prog_we, prog_addr, prog_data,
    input  opcode, out_value, pc_value, bus_value, flag_c, flag_z, bus_conflict
  );

  modport slave (
    input  ctrl, prog_we, prog_addr, prog_data,
    output opcode, out_value, pc_value, bus_value, flag_c, flag_z, bus_conflict
  );
endinterface

// File: rtl/sap_datapath.sv
// SAP-style 8-bit datapath: executes the control word's register transfers
// over a shared bus and returns the IR opcode to the control block.
module sap_datapath #(
  parameter int RAM_DEPTH = 16,
  parameter int DATA_W    = 8
) (
  input logic           clk,
  input logic           rst,
  sap_datapath_if.slave dp
);
  localparam int AW = 4;

  logic c_p_s, e_p_s, l_p_s, l_ma_s, l_md_s, ce_s, l_r_s, l_i_s;
  logic e_i_s, l_a_s, e_a_s, s_u_s, e_u_s, l_b_s, l_o_s;

  logic [AW-1:0]     pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d, ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic              fc_q, fc_d, fz_q, fz_d, conf_q, conf_d;
  logic [DATA_W-1:0] bus_s, ram_rd_s, alu_res_s;
  logic [DATA_W:0]   alu_sum_s;
  logic [2:0]        drv_cnt_s;
  logic [DATA_W-1:0] mem_q [RAM_DEPTH];

  // Active-low strobes are folded to active-high here so the rest reads uniformly.
  assign c_p_s  = dp.ctrl[14];
  assign e_p_s  = dp.ctrl[13];
  assign l_p_s  = dp.ctrl[12];
  assign l_ma_s = ~dp.ctrl[11];
  assign l_md_s = ~dp.ctrl[10];
  assign ce_s   = ~dp.ctrl[9];
  assign l_r_s  = ~dp.ctrl[8];
  assign l_i_s  = ~dp.ctrl[7];
  assign e_i_s  = ~dp.ctrl[6];
  assign l_a_s  = ~dp.ctrl[5];
  assign e_a_s  = dp.ctrl[4];
  assign s_u_s  = dp.ctrl[3];
  assign e_u_s  = dp.ctrl[2];
  assign l_b_s  = ~dp.ctrl[1];
  assign l_o_s  = ~dp.ctrl[0];

  assign ram_rd_s  = mem_q[mar_q];
  assign alu_sum_s = {1'b0, a_q} + {1'b0, (s_u_s ? ~b_q : b_q)} + {{DATA_W{1'b0}}, s_u_s};
  assign alu_res_s = alu_sum_s[DATA_W-1:0];
  assign drv_cnt_s = {2'b00, e_p_s} + {2'b00, ce_s} + {2'b00, e_i_s}
                   + {2'b00, e_a_s} + {2'b00, e_u_s};

  // Bus mux, fixed priority
  always_comb begin
    bus_s = {DATA_W{1'b0}};
    if (e_p_s) begin
      bus_s = {{(DATA_W-AW){1'b0}}, pc_q};
    end else if (ce_s) begin
      bus_s = ram_rd_s;
    end else if (e_i_s) begin
      bus_s = {{(DATA_W-AW){1'b0}}, ir_q[AW-1:0]};
    end else if (e_a_s) begin
      bus_s = a_q;
    end else if (e_u_s) begin
      bus_s = alu_res_s;
    end else begin
      bus_s = {DATA_W{1'b0}};
    end
  end

  // Next-state for all architectural registers
  always_comb begin
    pc_d   = pc_q;
    mar_d  = l_ma_s ? bus_s[AW-1:0] : mar_q;
    mdr_d  = l_md_s ? bus_s : mdr_q;
    ir_d   = l_i_s  ? bus_s : ir_q;
    a_d    = l_a_s  ? bus_s : a_q;
    b_d    = l_b_s  ? bus_s : b_q;
    out_d  = l_o_s  ? bus_s : out_q;
    fc_d   = fc_q;
    fz_d   = fz_q;
    conf_d = conf_q | (drv_cnt_s >= 3'd2);
    if (l_p_s) begin
      pc_d = bus_s[AW-1:0];
    end else if (c_p_s) begin
      pc_d = pc_q + 4'd1;
    end else begin
      pc_d = pc_q;
    end
    if (e_u_s) begin
      fc_d = alu_sum_s[DATA_W];
      fz_d = (alu_res_s == {DATA_W{1'b0}});
    end else begin
      fc_d = fc_q;
      fz_d = fz_q;
    end
  end

  // Register file with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= 4'd0;
      mar_q  <= 4'd0;
      mdr_q  <= {DATA_W{1'b0}};
      ir_q   <= {DATA_W{1'b0}};
      a_q    <= {DATA_W{1'b0}};
      b_q    <= {DATA_W{1'b0}};
      out_q  <= {DATA_W{1'b0}};
      fc_q   <= 1'b0;
      fz_q   <= 1'b0;
      conf_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      mar_q  <= mar_d;
      mdr_q  <= mdr_d;
      ir_q   <= ir_d;
      a_q    <= a_d;
      b_q    <= b_d;
      out_q  <= out_d;
      fc_q   <= fc_d;
      fz_q   <= fz_d;
      conf_q <= conf_d;
    end
  end

  // RAM keeps contents through reset; the program port is the later write so it wins on a clash
  always_ff @(posedge clk) begin
    if (l_r_s && !rst) begin
      mem_q[mar_q] <= mdr_q;
    end
    if (dp.prog_we) begin
      mem_q[dp.prog_addr] <= dp.prog_data;
    end
  end

  assign dp.opcode       = ir_q[DATA_W-1 -: 4];
  assign dp.out_value    = out_q;
  assign dp.pc_value     = pc_q;
  assign dp.bus_value    = bus_s;
  assign dp.flag_c       = fc_q;
  assign dp.flag_z       = fz_q;
  assign dp.bus_conflict = conf_q;
endmodule

// File: tb/tb_sap_datapath.sv
// Scoreboard bench for sap_datapath: directed program walk then random control
// words, checked against an arithmetic reference model.
module tb_sap_datapath;
  localparam logic [14:0] IDLE  = 15'b000111111100011;
  localparam logic [14:0] M_CP  = 15'h4000, M_EP = 15'h2000, M_LP = 15'h1000;
  localparam logic [14:0] M_LMA = 15'h0800, M_LMD = 15'h0400, M_CE = 15'h0200;
  localparam logic [14:0] M_LR  = 15'h0100, M_LI = 15'h0080, M_EI = 15'h0040;
  localparam logic [14:0] M_LA  = 15'h0020, M_EA = 15'h0010, M_SU = 15'h0008;
  localparam logic [14:0] M_EU  = 15'h0004, M_LB = 15'h0002, M_LO = 15'h0001;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] out;
    logic [3:0] pc;
    logic [7:0] bus;
    logic       fc;
    logic       fz;
    logic       conf;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sap_datapath_if dif ();
  sap_datapath dut (.clk(clk), .rst(rst), .dp(dif.slave));

  always #5 clk = ~clk;

  // reference model state
  int m_pc, m_mar, m_mdr, m_ir, m_a, m_b, m_out;
  bit m_fc, m_fz, m_conf;
  int m_mem [16];

  obs_t  sb_q [$];
  string tag_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [14:0] cw(input logic [14:0] mask);
    return IDLE ^ mask;
  endfunction

  // Model's view of the bus and the driver count for a control word
  function automatic int model_bus(input logic [14:0] c, output int ndrv);
    int alu;
    ndrv = int'(c[13]) + int'(!c[9]) + int'(!c[6]) + int'(c[4]) + int'(c[2]);
    alu = c[3] ? (m_a - m_b) & 255 : (m_a + m_b) & 255;
    if (c[13]) return m_pc;
    if (!c[9]) return m_mem[m_mar];
    if (!c[6]) return m_ir % 16;
    if (c[4])  return m_a;
    if (c[2])  return alu;
    return 0;
  endfunction

  task automatic step(input logic [14:0] c, input logic r, input string tag,
                      input logic pwe = 1'b0, input logic [3:0] pa = 4'd0,
                      input logic [7:0] pd = 8'd0);
    int b, nd, sum;
    obs_t e;
    dif.ctrl = c; rst = r;
    dif.prog_we = pwe; dif.prog_addr = pa; dif.prog_data = pd;
    b = model_bus(c, nd);
    e.op = 4'(m_ir / 16); e.out = 8'(m_out); e.pc = 4'(m_pc); e.bus = 8'(b);
    e.fc = m_fc; e.fz = m_fz; e.conf = m_conf;
    sb_q.push_back(e); tag_q.push_back(tag);
    @(posedge clk);
    if (!r && !c[8]) m_mem[m_mar] = m_mdr;
    if (pwe) m_mem[pa] = pd;
    if (r) begin
      m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
      m_fc = 0; m_fz = 0; m_conf = 0;
    end else begin
      if (nd >= 2) m_conf = 1;
      if (c[2]) begin
        sum = c[3] ? m_a - m_b : m_a + m_b;
        m_fc = c[3] ? (m_a >= m_b) : (sum > 255);
        m_fz = ((sum & 255) == 0);
      end
      if (c[12]) m_pc = b % 16;
      else if (c[14]) m_pc = (m_pc + 1) % 16;
      if (!c[11]) m_mar = b % 16;
      if (!c[10]) m_mdr = b;
      if (!c[7])  m_ir = b;
      if (!c[5])  m_a = b;
      if (!c[1])  m_b = b;
      if (!c[0])  m_out = b;
    end
    #1;
  endtask

  // Monitor: every cycle with a pending expectation, compare DUT outputs mid-cycle
  always @(negedge clk) begin
    obs_t a, e;
    string t;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front(); t = tag_q.pop_front();
      a.op = dif.opcode; a.out = dif.out_value; a.pc = dif.pc_value;
      a.bus = dif.bus_value; a.fc = dif.flag_c; a.fz = dif.flag_z;
      a.conf = dif.bus_conflict;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got op=%h out=%h pc=%h bus=%h c=%b z=%b conf=%b, want op=%h out=%h pc=%h bus=%h c=%b z=%b conf=%b",
                 t, a.op, a.out, a.pc, a.bus, a.fc, a.fz, a.conf,
                 e.op, e.out, e.pc, e.bus, e.fc, e.fz, e.conf);
      end
    end
  end

  initial begin
    logic [7:0] prog [16];
    int wait_cyc;
    prog = '{8'h4E, 8'h2D, 8'hFF, 8'h01, 8'h0F, 8'h3C, 8'h0A, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09, 8'h07, 8'h05};
    dif.ctrl = 15'd0; dif.prog_we = 1'b0; dif.prog_addr = 4'd0; dif.prog_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
    m_fc = 0; m_fz = 0; m_conf = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;

    for (int i = 0; i < 16; i++) step(IDLE, 1'b1, "prog_load", 1'b1, 4'(i), prog[i]);
    step(IDLE, 1'b0, "reset_state");

    // 1: fetch / execute LDA 14
    step(cw(M_EP | M_LMA), 1'b0, "fetch_mar");
    step(cw(M_CE | M_LI | M_CP), 1'b0, "fetch_ir");
    step(cw(M_EI | M_LMA), 1'b0, "opcode_pc");
    step(cw(M_CE | M_LA), 1'b0, "lda");
    step(cw(M_EA), 1'b0, "a_is_07");
    step(cw(M_EP | M_LMA), 1'b0, "fetch2_mar");
    step(cw(M_CE | M_LI | M_CP), 1'b0, "fetch2_ir");
    step(cw(M_EI | M_LMA), 1'b0, "op2_mar");
    step(cw(M_CE | M_LB), 1'b0, "ldb");
    // 2: ALU
    step(cw(M_EU | M_LO), 1'b0, "add_7_9");
    step(cw(M_EU | M_SU | M_LO), 1'b0, "sub_7_9");
    step(cw(M_CE | M_LA), 1'b0, "a_9");
    step(cw(M_EU | M_SU | M_LO), 1'b0, "sub_9_9");
    // 3: FF + 01
    step(cw(M_EP | M_LMA), 1'b0, "mar_2");
    step(cw(M_CE | M_LA | M_CP), 1'b0, "a_ff");
    step(cw(M_EP | M_LMA), 1'b0, "mar_3");
    step(cw(M_CE | M_LB | M_CP), 1'b0, "b_01");
    step(cw(M_EU | M_LO), 1'b0, "add_ff_01");
    // 4: PC wrap and load-beats-increment
    step(cw(M_EP | M_LMA), 1'b0, "mar_4");
    step(cw(M_CE | M_LP), 1'b0, "pc_15");
    step(cw(M_EP | M_LMA), 1'b0, "mar_15");
    step(cw(M_CP), 1'b0, "pc_wrap");
    step(cw(M_CE | M_LP | M_CP), 1'b0, "lp_beats_cp");
    // 5: store
    step(cw(M_EP | M_LMA), 1'b0, "mar_5");
    step(cw(M_CE | M_LA | M_CP), 1'b0, "a_3c");
    step(cw(M_EP | M_LMA), 1'b0, "mar_6");
    step(cw(M_CE | M_LMA), 1'b0, "mar_a");
    step(cw(M_EA | M_LMD), 1'b0, "mdr_3c");
    step(cw(M_LR), 1'b0, "sta");
    step(cw(M_CE | M_LO), 1'b0, "read_back");
    step(cw(M_EP | M_LMD), 1'b0, "mdr_pc");
    step(cw(M_EA | M_LMD | M_LR), 1'b0, "old_mdr_write");
    step(cw(M_CE | M_LO), 1'b0, "read_old_mdr");
    step(cw(M_CE | M_LO | M_LR), 1'b0, "read_during_write");
    step(cw(M_CE | M_LO), 1'b0, "read_new");
    step(cw(M_EA | M_LA), 1'b0, "self_reload");
    step(cw(M_LR), 1'b0, "prog_vs_ram", 1'b1, 4'hA, 8'h5A);
    step(cw(M_CE | M_LO), 1'b0, "prog_wins");
    // 6: conflict, reset, idle
    step(cw(M_EP | M_EA | M_LO), 1'b0, "conflict");
    step(IDLE, 1'b0, "conflict_sticky");
    step(IDLE, 1'b0, "conflict_sticky2");
    step(15'd0, 1'b1, "reset_ctrl0");
    step(15'd0, 1'b1, "reset_ctrl0b");
    for (int i = 0; i < 10; i++) step(IDLE, 1'b0, "idle");
    step(cw(M_CE | M_LO), 1'b0, "ram_kept");
    step(IDLE, 1'b0, "ram_kept_out");

    // random control words, occasional program writes and resets
    for (int i = 0; i < 400; i++) begin
      logic [14:0] c;
      logic r, pwe;
      c   = 15'($urandom);
      r   = ($urandom_range(0, 39) == 0);
      pwe = ($urandom_range(0, 5) == 0);
      step(c, r, "random", pwe, 4'($urandom), 8'($urandom));
    end
    step(IDLE, 1'b0, "final");

    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 5) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d pending, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
